// File: rtl/key_event_controller.sv
// key_event_controller: PS/2 scan-code handshake and decoder that turns W/S/R and arrow keys into held movement levels and a restart pulse.
module key_event_controller #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic       read,
    input  logic       flush,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       restart_pulse,
    output logic       timeout_err
);
    typedef enum logic [1:0] {ACCEPT, ACK, DRAIN} hs_t;
    typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK} pf_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    hs_t hs;
    pf_t pf, pf_eff, pf_next;
    logic [CW-1:0] cnt;
    logic [4:0] held, sel, held_next;
    logic fire, take, ext, brk;
    // held bits: 0=W, 1=S, 2=R, 3=p2 up, 4=p2 down
    always_comb begin
        fire = pf != BASE && cnt == CW'(TIMEOUT_CYCLES - 1);
        take = hs == ACCEPT && scan_ready;
        pf_eff = fire ? BASE : pf;
        ext = pf_eff == EXT || pf_eff == EXT_BRK;
        brk = pf_eff == BRK || pf_eff == EXT_BRK;
        sel = {ext && scan_code == 8'h72, ext && scan_code == 8'h75,
               !ext && scan_code == 8'h2D, !ext && scan_code == 8'h1B, !ext && scan_code == 8'h1D};
        pf_next = (scan_code == 8'hE0 && pf_eff == BASE) ? EXT :
                  (scan_code == 8'hF0 && pf_eff == BASE) ? BRK :
                  (scan_code == 8'hF0 && pf_eff == EXT) ? EXT_BRK : BASE;
        held_next = brk ? held & ~sel : held | sel;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            hs <= ACCEPT;
            pf <= BASE;
            cnt <= '0;
            held <= '0;
            read <= 1'b0;
            restart_pulse <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            read <= take;
            restart_pulse <= take && !brk && sel[2] && !held[2];
            timeout_err <= fire;
            hs <= take ? ACK : hs == ACK ? DRAIN : (hs == DRAIN && !scan_ready) ? ACCEPT : hs;
            pf <= take ? pf_next : pf_eff;
            cnt <= (take || pf_eff == BASE) ? '0 : cnt + 1'b1;
            held <= flush ? '0 : take ? held_next : held;
        end
    end
    assign p1_down = held[1];
    assign p1_up = held[0] & ~held[1];
    assign p2_down = held[4];
    assign p2_up = held[3] & ~held[4];
endmodule

// File: tb/tb_key_event_controller.sv
// tb_key_event_controller: directed and random byte streams checked against a prefix-queue model of the key decoder.
module tb_key_event_controller;
    localparam int TO = 16;
    logic clock = 0, reset = 1, scan_ready = 0, flush = 0;
    logic [7:0] scan_code = 0;
    logic read, p1_up, p1_down, p2_up, p2_down, restart_pulse, timeout_err;
    int n_checks = 0, n_errs = 0, cyc = 0;
    int read_cnt = 0, rst_cnt = 0, to_cnt = 0;
    int exp_read = 0, exp_rst = 0, exp_to = 0, t_last = 0;
    bit h_w, h_s, h_r, h_u, h_d, pulse_now;
    logic [7:0] pre[$];
    logic [7:0] pool[9] = '{8'h1D, 8'h1B, 8'h2D, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hE1, 8'h33};

    key_event_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .scan_code(scan_code), .scan_ready(scan_ready),
        .read(read), .flush(flush), .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up),
        .p2_down(p2_down), .restart_pulse(restart_pulse), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        read_cnt += int'(read);
        rst_cnt += int'(restart_pulse);
        to_cnt += int'(timeout_err);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        {h_w, h_s, h_r, h_u, h_d} = '0;
    endtask

    task automatic model_expire(input int now);
        if (pre.size() != 0 && now - t_last >= TO) begin
            pre.delete();
            exp_to++;
        end
    endtask

    task automatic model_byte(input logic [7:0] c, input bit fl, input int now);
        bit e, b;
        model_expire(now);
        exp_read++;
        pulse_now = 0;
        t_last = now;
        e = pre.size() > 0 && pre[0] == 8'hE0;
        b = pre.size() > 0 && pre[pre.size()-1] == 8'hF0;
        if (c == 8'hE0 && pre.size() == 0) pre.push_back(c);
        else if (c == 8'hF0 && (pre.size() == 0 || (pre.size() == 1 && e))) pre.push_back(c);
        else begin
            pre.delete();
            if (!e && c == 8'h1D) h_w = !b;
            if (!e && c == 8'h1B) h_s = !b;
            if (!e && c == 8'h2D) begin
                if (!b && !h_r) begin
                    pulse_now = 1;
                    exp_rst++;
                end
                h_r = !b;
            end
            if (e && c == 8'h75) h_u = !b;
            if (e && c == 8'h72) h_d = !b;
        end
        if (fl) model_clear();
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".p1_up"}, p1_up, h_w && !h_s);
        check({tag, ".p1_down"}, p1_down, h_s);
        check({tag, ".p2_up"}, p2_up, h_u && !h_d);
        check({tag, ".p2_down"}, p2_down, h_d);
    endtask

    task automatic check_counts(input string tag);
        @(negedge clock); #1;
        model_expire(cyc);
        check({tag, ".reads"}, read_cnt, exp_read);
        check({tag, ".restarts"}, rst_cnt, exp_rst);
        check({tag, ".timeouts"}, to_cnt, exp_to);
    endtask

    task automatic send(input logic [7:0] c, input int hold, input bit fl);
        scan_code = c;
        scan_ready = 1;
        flush = fl;
        @(posedge clock); #1;
        flush = 0;
        model_byte(c, fl, cyc);
        check("ack", read, 1);
        check("restart_now", restart_pulse, pulse_now);
        check_outs("byte");
        check_counts("byte");
        repeat (hold - 1) begin @(posedge clock); #1; end
        scan_ready = 0;
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
        check_counts("idle");
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        pre.delete();
        model_clear();
        check("rst.read", read, 0);
        check("rst.restart", restart_pulse, 0);
        check("rst.timeout", timeout_err, 0);
        check_outs("rst");
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        send(8'h1D, 3, 0);
        check("p1_up_after_W", p1_up, 1);
        send(8'hF0, 1, 0); send(8'h1D, 1, 0);
        send(8'h1D, 1, 0); send(8'h1B, 2, 0);
        send(8'hF0, 1, 0); send(8'h1B, 1, 0);
        send(8'hE0, 1, 0); send(8'h72, 1, 0);
        send(8'hE0, 1, 0); send(8'hF0, 1, 0); send(8'h72, 1, 0);
        send(8'h72, 1, 0);
        send(8'h2D, 1, 0); send(8'h2D, 2, 0); send(8'h2D, 1, 0);
        send(8'hF0, 1, 0); send(8'h2D, 1, 0); send(8'h2D, 1, 0);
        check("two_restarts", rst_cnt, 2);
        send(8'hE0, 1, 0);
        idle(20);
        check("one_timeout", to_cnt, 1);
        send(8'h75, 1, 0);
        check("p2_up_after_timeout", p2_up, 0);
        send(8'hE0, 1, 0);
        do_reset();
        send(8'h75, 1, 0);
        send(8'h1D, 1, 1);
        check("flush_wins", p1_up, 0);
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                flush = 1;
                @(posedge clock); #1;
                flush = 0;
                model_clear();
                check_outs("flush");
            end
            send(pool[$urandom_range(0, 8)], $urandom_range(1, 3), $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(8, 16));
            else if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
        end
        idle(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
